aesl_dep_status_sampler: RTL

AESL_DEP_STATUS_SAMPLER -- requirements
Module: aesl_dep_status_sampler

---
 rtl/aesl_deadlock_pkg.sv | 20 ++
 rtl/aesl_dep_filter_bit.sv | 63 ++++++
 rtl/aesl_dep_status_sampler.sv | 88 ++++++++
 3 files changed

// File: rtl/aesl_deadlock_pkg.sv
// Shared widths and defaults for the deadlock-detection dependency logic.
// Holds the run-counter width, rise-counter width and a saturating adder.
package aesl_deadlock_pkg;

    localparam int CNT_W      = 8;
    localparam int RISE_W     = 16;
    localparam int STABLE_DEF = 4;

    localparam logic [RISE_W-1:0] RISE_MAX = '1;

    function automatic logic [RISE_W-1:0] sat_add(
        input logic [RISE_W-1:0] a,
        input logic [RISE_W-1:0] b
    );
        logic [RISE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[RISE_W] ? RISE_MAX : s[RISE_W-1:0];
    endfunction

endpackage

// File: rtl/aesl_dep_filter_bit.sv
// One dependency bit: optional run-length filter plus output flop, with freeze.
// Filtering is built only when AESL_DEP_FILTER_EN is defined.
module aesl_dep_filter_bit
    import aesl_deadlock_pkg::*;
`ifdef AESL_DEP_FILTER_EN
#(
    parameter int STABLE_CYCLES = STABLE_DEF
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic freeze,
    output logic vld_nxt,
    output logic vld
);

`ifdef AESL_DEP_FILTER_EN
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STABLE_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next run count and output: saturate while raw holds, clear on any gap.
    always_comb begin
        cnt_nxt = cnt;
        vld_nxt = vld;
        if (!freeze) begin
            if (raw) begin
                cnt_nxt = (cnt >= LIM) ? LIM : cnt + CNT_W'(1);
            end else begin
                cnt_nxt = '0;
            end
            vld_nxt = raw && (cnt_nxt == LIM);
        end
    end

    // Run counter state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    // Unfiltered: the output is simply raw delayed one cycle unless frozen.
    always_comb begin
        vld_nxt = freeze ? vld : raw;
    end
`endif

    // Registered dependency bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld <= 1'b0;
        end else begin
            vld <= vld_nxt;
        end
    end

endmodule

// File: rtl/aesl_dep_status_sampler.sv
// Samples per-process FIFO block / ready status into a filtered dependency
// vector. Optional filtering is enabled by the AESL_DEP_FILTER_EN macro.
module aesl_dep_status_sampler
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_PROC      = 3,
    parameter int NUM_DEP       = 2,
    parameter int STABLE_CYCLES = STABLE_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_PROC*NUM_DEP-1:0]  blk_n_vec,
    input  logic [NUM_PROC-1:0]          ap_idle_vec,
    input  logic [NUM_PROC-1:0]          ready_cnt_vec,
    input  logic [NUM_PROC*NUM_DEP-1:0]  peer_ready_vec,
    input  logic                         dl_detect_in,
    output logic [NUM_PROC*NUM_DEP-1:0]  proc_dep_vld_vec,
    output logic [NUM_PROC-1:0]          ap_idle_dly_vec,
    output logic [RISE_W-1:0]            dep_rise_cnt
);

    localparam int NB = NUM_PROC * NUM_DEP;

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_stable
        $error("STABLE_CYCLES out of range");
    end

    logic [NB-1:0]     raw;
    logic [NB-1:0]     vld_nxt;
    logic [RISE_W-1:0] rise_num;

    // Raw dependency: FIFO blocked, or this process is done while its peer is not.
    always_comb begin
        raw = '0;
        for (int p = 0; p < NUM_PROC; p++) begin
            for (int d = 0; d < NUM_DEP; d++) begin
                raw[p*NUM_DEP+d] = ~blk_n_vec[p*NUM_DEP+d]
                    | (ready_cnt_vec[p] & ap_idle_vec[p]
                       & ~peer_ready_vec[p*NUM_DEP+d]);
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bit
        aesl_dep_filter_bit
`ifdef AESL_DEP_FILTER_EN
        #(
            .STABLE_CYCLES(STABLE_CYCLES)
        )
`endif
        u_bit (
            .clock   (clock),
            .reset   (reset),
            .raw     (raw[b]),
            .freeze  (dl_detect_in),
            .vld_nxt (vld_nxt[b]),
            .vld     (proc_dep_vld_vec[b])
        );
    end

    // Number of bits going 0->1 on the coming edge.
    always_comb begin
        rise_num = '0;
        for (int b = 0; b < NB; b++) begin
            rise_num = rise_num
                + RISE_W'(vld_nxt[b] & ~proc_dep_vld_vec[b]);
        end
    end

    // Saturating rise counter, held while a deadlock is flagged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dep_rise_cnt <= '0;
        end else if (!dl_detect_in) begin
            dep_rise_cnt <= sat_add(dep_rise_cnt, rise_num);
        end
    end

    // Idle delay runs every cycle, even during a freeze.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ap_idle_dly_vec <= '0;
        end else begin
            ap_idle_dly_vec <= ap_idle_vec;
        end
    end

endmodule
